bram_stream_loader: RTL and testbench



---
 rtl/bram_stream_loader.sv | 132 +++++++++++++
 tb/tb_bram_stream_loader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_stream_loader.sv
// Byte-stream to block-RAM write-port loader.
// Packs little-endian bytes into 32-bit words and writes them from a base address.
module bram_stream_loader #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  word_count,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  wr_en,
  output logic                  wr_we,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  words_written
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    DONE
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [CNT_WIDTH-1:0]    cnt_q;
  logic [1:0]              idx;
  logic [DATA_WIDTH-1:0]   word_buf;
  logic [CNT_WIDTH-1:0]    ww_inc;

  assign ww_inc = words_written + CNT_WIDTH'(1);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and stream-ready decode.
  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (word_count == '0) ? DONE : COLLECT;
        end
      end
      COLLECT: begin
        s_ready = 1'b1;
        if (s_valid && (idx == 2'd3)) begin
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        state_nxt = (ww_inc == cnt_q) ? DONE : COLLECT;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: byte assembly, write-port drive and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q        <= '0;
      cnt_q         <= '0;
      idx           <= '0;
      word_buf      <= '0;
      wr_en         <= 1'b0;
      wr_we         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      words_written <= '0;
    end else begin
      wr_en <= 1'b0;
      wr_we <= 1'b0;
      done  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            base_q        <= base_addr;
            cnt_q         <= word_count;
            words_written <= '0;
            idx           <= '0;
            busy          <= 1'b1;
          end
        end
        COLLECT: begin
          if (s_valid) begin
            word_buf[{idx, 3'b000} +: 8] <= s_data;
            idx                          <= idx + 2'd1;
          end
        end
        WRITE: begin
          wr_en         <= 1'b1;
          wr_we         <= 1'b1;
          wr_addr       <= base_q + ADDR_WIDTH'(words_written);
          wr_data       <= word_buf;
          words_written <= ww_inc;
          idx           <= '0;
        end
        DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_stream_loader.sv
// Directed bench for bram_stream_loader.
// Table of load cases plus hand sequences for zero count, restart and reset.
module tb_bram_stream_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  base_addr = '0;
  logic [9:0]  word_count = '0;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        wr_en;
  logic        wr_we;
  logic [8:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic [9:0]  words_written;

  bram_stream_loader #(
    .ADDR_WIDTH(9),
    .DATA_WIDTH(32),
    .CNT_WIDTH(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .base_addr(base_addr),
    .word_count(word_count),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .wr_en(wr_en),
    .wr_we(wr_we),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .busy(busy),
    .done(done),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int          cyc = 0;
  logic [8:0]  log_addr[$];
  logic [31:0] log_data[$];
  int          log_cyc[$];
  int          done_cnt = 0;
  int          sready_cnt = 0;
  int          we_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write-port / status monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (wr_en) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
      log_cyc.push_back(cyc);
    end
    if (wr_en != wr_we) we_bad <= we_bad + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (s_ready) sready_cnt <= sready_cnt + 1;
  end

  typedef struct {
    logic [8:0]  base;
    logic [9:0]  cnt;
    logic [63:0] bytes;
    int          stall_at;
    int          stall_len;
    logic [8:0]  a0;
    logic [31:0] d0;
    logic [8:0]  a1;
    logic [31:0] d1;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [8:0] b, input logic [9:0] c);
    base_addr  = b;
    word_count = c;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n       = 0;
    s_valid = 1'b1;
    s_data  = b;
    while (!s_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("send_timeout", 64'(n), 64'(0));
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    chk("done_seen", 64'(done), 64'(1));
  endtask

  task automatic run_case(input int id, input vec_t v);
    int lb;
    int db;
    int nw;
    string tag;
    tag = $sformatf("case%0d", id);
    lb  = log_addr.size();
    db  = done_cnt;
    do_start(v.base, v.cnt);
    chk({tag, "_busy_start"}, 64'(busy), 64'(1));
    for (int k = 0; k < 4 * int'(v.cnt); k++) begin
      send_byte(v.bytes[8*k +: 8]);
      if (k == v.stall_at) begin
        for (int s = 0; s < v.stall_len; s++) begin
          chk({tag, "_stall_ready"}, 64'(s_ready), 64'(1));
          tick();
        end
        chk({tag, "_stall_nowrite"}, 64'(log_addr.size() - lb), 64'(0));
      end
    end
    wait_done();
    chk({tag, "_ww"}, 64'(words_written), 64'(v.cnt));
    chk({tag, "_busy_end"}, 64'(busy), 64'(0));
    repeat (3) tick();
    chk({tag, "_ready_idle"}, 64'(s_ready), 64'(0));
    chk({tag, "_done_once"}, 64'(done_cnt - db), 64'(1));
    nw = log_addr.size() - lb;
    chk({tag, "_nwrites"}, 64'(nw), 64'(v.cnt));
    if (nw >= 1) begin
      chk({tag, "_a0"}, 64'(log_addr[lb]), 64'(v.a0));
      chk({tag, "_d0"}, 64'(log_data[lb]), 64'(v.d0));
    end
    if (nw >= 2 && v.cnt == 2) begin
      chk({tag, "_a1"}, 64'(log_addr[lb+1]), 64'(v.a1));
      chk({tag, "_d1"}, 64'(log_data[lb+1]), 64'(v.d1));
      chk({tag, "_gap"}, 64'(log_cyc[lb+1] - log_cyc[lb]), 64'(5));
    end
  endtask

  initial begin
    int lb;
    int db;
    int sb;

    vecs[0] = '{9'h010, 10'd2, 64'hDEADBEEF_12345678, -1, 0,
                9'h010, 32'h12345678, 9'h011, 32'hDEADBEEF};
    vecs[1] = '{9'h1FF, 10'd2, 64'h88776655_44332211, -1, 0,
                9'h1FF, 32'h44332211, 9'h000, 32'h88776655};
    vecs[2] = '{9'h0A0, 10'd2, 64'h3CC35AA5_04030201, 2, 7,
                9'h0A0, 32'h04030201, 9'h0A1, 32'h3CC35AA5};
    vecs[3] = '{9'h123, 10'd1, 64'h00000000_EFBEADDE, -1, 0,
                9'h123, 32'hEFBEADDE, 9'h000, 32'h00000000};

    reset = 1'b1;
    tick();
    tick();
    chk("reset_outs",
        64'({s_ready, wr_en, wr_we, wr_addr, wr_data, busy, done}),
        64'(0));
    chk("reset_ww", 64'(words_written), 64'(0));
    reset = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) begin
      run_case(i, vecs[i]);
    end

    // Zero-length load: done without any write or ready.
    lb = log_addr.size();
    db = done_cnt;
    sb = sready_cnt;
    do_start(9'h055, 10'd0);
    chk("zero_busy", 64'(busy), 64'(1));
    chk("zero_done_early", 64'(done), 64'(0));
    chk("zero_ready", 64'(s_ready), 64'(0));
    tick();
    chk("zero_done", 64'(done), 64'(1));
    chk("zero_busy_end", 64'(busy), 64'(0));
    chk("zero_ww", 64'(words_written), 64'(0));
    repeat (3) tick();
    chk("zero_nwrites", 64'(log_addr.size() - lb), 64'(0));
    chk("zero_sready", 64'(sready_cnt - sb), 64'(0));
    chk("zero_done_once", 64'(done_cnt - db), 64'(1));

    // Start while busy is ignored.
    lb = log_addr.size();
    db = done_cnt;
    do_start(9'h040, 10'd2);
    send_byte(8'h01);
    send_byte(8'h02);
    base_addr  = 9'h100;
    word_count = 10'd1;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    chk("mid_ready", 64'(s_ready), 64'(1));
    send_byte(8'h03);
    send_byte(8'h04);
    send_byte(8'h05);
    send_byte(8'h06);
    send_byte(8'h07);
    send_byte(8'h08);
    wait_done();
    chk("mid_ww", 64'(words_written), 64'(2));
    repeat (3) tick();
    chk("mid_nwrites", 64'(log_addr.size() - lb), 64'(2));
    chk("mid_done_once", 64'(done_cnt - db), 64'(1));
    if (log_addr.size() - lb >= 2) begin
      chk("mid_a0", 64'(log_addr[lb]), 64'(9'h040));
      chk("mid_d0", 64'(log_data[lb]), 64'(32'h04030201));
      chk("mid_a1", 64'(log_addr[lb+1]), 64'(9'h041));
      chk("mid_d1", 64'(log_data[lb+1]), 64'(32'h08070605));
    end

    // Reset mid-word discards the partial word.
    lb = log_addr.size();
    do_start(9'h060, 10'd2);
    send_byte(8'h99);
    send_byte(8'h98);
    reset = 1'b1;
    #1;
    chk("rst_mid_outs",
        64'({s_ready, wr_en, wr_we, wr_addr, wr_data, busy, done}),
        64'(0));
    chk("rst_mid_ww", 64'(words_written), 64'(0));
    tick();
    reset = 1'b0;
    tick();
    chk("rst_mid_nowrite", 64'(log_addr.size() - lb), 64'(0));
    do_start(9'h020, 10'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hDD);
    wait_done();
    repeat (2) tick();
    chk("rst_new_nwrites", 64'(log_addr.size() - lb), 64'(1));
    if (log_addr.size() - lb >= 1) begin
      chk("rst_new_a0", 64'(log_addr[lb]), 64'(9'h020));
      chk("rst_new_d0", 64'(log_data[lb]), 64'(32'hDDCCBBAA));
    end
    chk("we_follows_en", 64'(we_bad), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
